// File: rtl/dm_agu.sv
// dm_agu: data-memory address generation unit with a private single-port
// word store. An access is accepted from IDLE, performed in ACCESS and
// acknowledged with a one-cycle done pulse in RESP. Addresses come either
// from base+offset (wrapping modulo 2**AW) or from an internal
// auto-incrementing pointer.
module dm_agu #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_en,
    input  logic          ptr_mode,
    input  logic [AW-1:0] base,
    input  logic [7:0]    offset,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] eff_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] ptr;
    logic [AW-1:0] abs_addr;
    logic [AW-1:0] addr_sel;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          mem_we;
    logic          mem_re;
    logic          ptr_adv;

    // Effective address candidate: base plus zero-extended offset, carry dropped, or the pointer
    always_comb begin
        abs_addr = base + AW'(offset);
        addr_sel = ptr_mode ? ptr : abs_addr;
    end

    // Next-state and control decode; start is only honoured in IDLE so nothing queues while busy
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        ptr_adv   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_we    = wr_q;
                mem_re    = ~wr_q;
                ptr_adv   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset drops straight to IDLE, which aborts any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request at acceptance so later input changes cannot disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_addr <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
        end else if (accept) begin
            eff_addr <= addr_sel;
            wr_q     <= wr_en;
            wdata_q  <= wr_data;
        end
    end

    // Load result register; stores leave it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (mem_re) begin
            rd_data <= mem[eff_addr];
        end
    end

    // Pointer advances past the address just used, wrapping naturally at 2**AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (ptr_adv) begin
            ptr <= eff_addr + AW'(1);
        end
    end

    // Storage array is never reset; a store only lands if the FSM is still in ACCESS at the edge
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[eff_addr] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dm_agu.sv
// tb_dm_agu: directed self-checking bench for dm_agu.
module tb_dm_agu;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       wr_en;
    logic       ptr_mode;
    logic [9:0] base;
    logic [7:0] offset;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic [9:0] eff_addr;

    int checks;
    int errors;

    dm_agu #(.AW(10), .DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr_en    (wr_en),
        .ptr_mode (ptr_mode),
        .base     (base),
        .offset   (offset),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .eff_addr (eff_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access: drive at negedge, accept on the next posedge,
    // check busy/eff_addr, then done in RESP and idle afterwards.
    // When scramble is set the inputs are changed while the access is in flight.
    task automatic applyStimulus(input string tag, input logic wr, input logic pm,
                                 input logic [9:0] b, input logic [7:0] o,
                                 input logic [7:0] d, input logic [9:0] exp_addr,
                                 input logic scramble);
        @(negedge clk);
        start    = 1'b1;
        wr_en    = wr;
        ptr_mode = pm;
        base     = b;
        offset   = o;
        wr_data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            base    = 10'h200;
            offset  = 8'hFF;
            wr_data = 8'h00;
            wr_en   = ~wr;
        end
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_addr"}, 32'(eff_addr), 32'(exp_addr));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, 32'(done | busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_idx;
        int last_idx;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_en    = 1'b0;
        ptr_mode = 1'b0;
        base     = '0;
        offset   = '0;
        wr_data  = '0;

        // Reset state
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rd", 32'(rd_data), 32'd0);
        checkOutput("rst_addr", 32'(eff_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load at 0x015
        applyStimulus("st015", 1'b1, 1'b0, 10'h010, 8'h05, 8'hA5, 10'h015, 1'b0);
        applyStimulus("ld015", 1'b0, 1'b0, 10'h010, 8'h05, 8'h00, 10'h015, 1'b0);
        checkOutput("ld015_data", 32'(rd_data), 32'hA5);

        // Wrapping absolute store; rd_data must keep the previous load value
        applyStimulus("stwrap", 1'b1, 1'b0, 10'h3FF, 8'h02, 8'h3C, 10'h001, 1'b0);
        checkOutput("stwrap_rdkeep", 32'(rd_data), 32'hA5);
        // Pointer now sits at 0x002
        applyStimulus("ldptr", 1'b0, 1'b1, 10'h155, 8'h77, 8'h00, 10'h002, 1'b0);
        applyStimulus("ld001", 1'b0, 1'b0, 10'h000, 8'h01, 8'h00, 10'h001, 1'b0);
        checkOutput("ld001_data", 32'(rd_data), 32'h3C);

        // Pointer streaming across the top of memory
        applyStimulus("st3fe", 1'b1, 1'b0, 10'h3F0, 8'h0E, 8'h99, 10'h3FE, 1'b0);
        applyStimulus("pst11", 1'b1, 1'b1, 10'h000, 8'h00, 8'h11, 10'h3FF, 1'b0);
        applyStimulus("pst22", 1'b1, 1'b1, 10'h000, 8'h00, 8'h22, 10'h000, 1'b0);
        applyStimulus("ld3ff", 1'b0, 1'b0, 10'h3FF, 8'h00, 8'h00, 10'h3FF, 1'b0);
        checkOutput("ld3ff_data", 32'(rd_data), 32'h11);
        applyStimulus("ld000", 1'b0, 1'b0, 10'h300, 8'h00, 8'h00, 10'h300, 1'b0);
        applyStimulus("ld000b", 1'b0, 1'b0, 10'h3FF, 8'h01, 8'h00, 10'h000, 1'b0);
        checkOutput("ld000_data", 32'(rd_data), 32'h22);

        // Busy rejection: pointer at 0x101, start held for 9 edges
        applyStimulus("ld100", 1'b0, 1'b0, 10'h100, 8'h00, 8'h00, 10'h100, 1'b0);
        done_cnt  = 0;
        first_idx = -1;
        last_idx  = -1;
        @(negedge clk);
        start    = 1'b1;
        wr_en    = 1'b0;
        ptr_mode = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
            if (i == 9) start = 1'b0;
        end
        checkOutput("burst_count", 32'(done_cnt), 32'd3);
        checkOutput("burst_first", 32'(first_idx), 32'd2);
        checkOutput("burst_last", 32'(last_idx), 32'd8);
        checkOutput("burst_addr", 32'(eff_addr), 32'h103);

        // Reset during the ACCESS cycle of a store
        applyStimulus("st020", 1'b1, 1'b0, 10'h020, 8'h00, 8'h5A, 10'h020, 1'b0);
        applyStimulus("ld020", 1'b0, 1'b0, 10'h000, 8'h20, 8'h00, 10'h020, 1'b0);
        checkOutput("ld020_data", 32'(rd_data), 32'h5A);
        @(negedge clk);
        start    = 1'b1;
        wr_en    = 1'b1;
        ptr_mode = 1'b0;
        base     = 10'h020;
        offset   = 8'h00;
        wr_data  = 8'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("abort_inflight", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_rd", 32'(rd_data), 32'd0);
        checkOutput("abort_addr", 32'(eff_addr), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_nodone", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("ld020r", 1'b0, 1'b0, 10'h010, 8'h10, 8'h00, 10'h020, 1'b0);
        checkOutput("ld020r_data", 32'(rd_data), 32'h5A);

        // Input hold-off: inputs scrambled during the access
        applyStimulus("sthold", 1'b1, 1'b0, 10'h030, 8'h04, 8'hC3, 10'h034, 1'b1);
        checkOutput("sthold_addr", 32'(eff_addr), 32'h034);
        applyStimulus("ldhold", 1'b0, 1'b0, 10'h030, 8'h04, 8'h00, 10'h034, 1'b0);
        checkOutput("ldhold_data", 32'(rd_data), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
